rotozoom_sched: RTL and testbench

Per-frame parameter scheduler for the rotating/zooming texture generator. Once per frame, during vertical blanking, it advances the rotation angle and fetches sine, cosine and scale from a shared synchronous sine ROM. It then computes the texture-space strides and start offsets on a single time-shared 16x16 signed multiplier, and commits all results atomically at a fixed frame point. The pixel generator consumes the committed values; this block replaces its four parallel multipliers and its private ROM ports.

---
 rtl/rotozoom_sched.sv | 155 +++++++++++++++
 tb/tb_rotozoom_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rotozoom_sched.sv
// Per-frame rotozoom parameter scheduler: fetches sin/cos/scale from the shared ROM during blanking,
// derives strides and start offsets on one time-shared multiplier, and publishes them together at the commit line.
module rotozoom_sched #(
  parameter int V_ACTIVE     = 304,
  parameter int V_COMMIT     = 311,
  parameter int CX           = 194,
  parameter int CY           = 152,
  parameter int SCALE_SHIFT  = 3,
  parameter int OFFSET_SHIFT = 5
) (
  input  logic        clk7,
  input  logic        rst_n,
  input  logic [8:0]  hc,
  input  logic [8:0]  vc,
  input  logic        pause,
  input  logic [3:0]  step,
  output logic [7:0]  sin_addr,
  input  logic [15:0] sin_data,
  output logic [8:0]  angle,
  output logic [16:0] u_stride,
  output logic [16:0] v_stride,
  output logic [16:0] u_start0,
  output logic [16:0] v_start0,
  output logic        params_upd,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_M0, S_M1, S_M2, S_M3, S_WAIT
  } state_t;

  localparam logic signed [15:0] CX16 = 16'(CX);
  localparam logic signed [15:0] CY16 = 16'(CY);

  state_t             state, state_nxt;
  logic [8:0]         angle_work;
  logic [7:0]         addr_q;
  logic signed [15:0] vs, us, sc;
  logic [16:0]        u_stride_p, v_stride_p, u_start_p, v_start_p;
  logic               trigger, commit_pt, commit_go;
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] mul_p;
  logic [16:0]        stride_val, offset_val;

  assign trigger   = (hc == 9'd0) && (vc == 9'(V_ACTIVE));
  assign commit_pt = (hc == 9'd0) && (vc == 9'(V_COMMIT));
  assign commit_go = commit_pt && (state == S_WAIT);
  assign busy      = (state != S_IDLE) || params_upd;

  // Address leads the captured data by one cycle: sin, then cos (+quarter turn), then scale.
  always_comb begin
    sin_addr = addr_q;
    case (state)
      S_F0:    sin_addr = angle_work[7:0];
      S_F1:    sin_addr = angle_work[7:0] + 8'd64;
      S_F2:    sin_addr = angle_work[8:1];
      default: sin_addr = addr_q;
    endcase
  end

  // Single shared multiplier; the FSM state selects which operand pair it sees.
  always_comb begin
    mul_a = sc;
    mul_b = us;
    case (state)
      S_M1: begin mul_a = sc;   mul_b = vs; end
      S_M2: begin mul_a = CX16; mul_b = us; end
      S_M3: begin mul_a = CY16; mul_b = vs; end
      default: begin mul_a = sc; mul_b = us; end
    endcase
  end

  assign mul_p      = mul_a * mul_b;
  assign stride_val = 17'(mul_p >>> (16 + SCALE_SHIFT));
  assign offset_val = 17'(mul_p >>> (16 + OFFSET_SHIFT));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trigger) state_nxt = S_F0;
      S_F0:    state_nxt = S_F1;
      S_F1:    state_nxt = S_F2;
      S_F2:    state_nxt = S_F3;
      S_F3:    state_nxt = S_M0;
      S_M0:    state_nxt = S_M1;
      S_M1:    state_nxt = S_M2;
      S_M2:    state_nxt = S_M3;
      S_M3:    state_nxt = S_WAIT;
      S_WAIT:  if (commit_pt) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) begin
      angle_work <= '0;
      addr_q     <= '0;
      vs         <= '0;
      us         <= '0;
      sc         <= '0;
      u_stride_p <= '0;
      v_stride_p <= '0;
      u_start_p  <= '0;
      v_start_p  <= '0;
    end else begin
      addr_q <= sin_addr;
      if (state == S_IDLE && trigger)
        angle_work <= angle_work + (pause ? 9'd0 : {5'd0, step});
      case (state)
        S_F1: vs <= sin_data;
        S_F2: us <= sin_data;
        S_F3: sc <= sin_data;
        S_M0: u_stride_p <= stride_val;
        S_M1: v_stride_p <= stride_val;
        S_M2: u_start_p  <= -offset_val;
        S_M3: v_start_p  <= offset_val;
        default: ;
      endcase
    end
  end

  // Published values move together in one edge so the pixel generator never sees a mixed set.
  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) begin
      angle      <= '0;
      u_stride   <= '0;
      v_stride   <= '0;
      u_start0   <= '0;
      v_start0   <= '0;
      params_upd <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      params_upd <= commit_go;
      if (commit_go) begin
        angle    <= angle_work;
        u_stride <= u_stride_p;
        v_stride <= v_stride_p;
        u_start0 <= u_start_p;
        v_start0 <= v_start_p;
      end
      if ((trigger && state != S_IDLE) || (commit_pt && state != S_WAIT))
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rotozoom_sched.sv
// Directed bench for rotozoom_sched: table of per-frame vectors plus hand-written overrun and reset sequences.
module tb_rotozoom_sched;
  localparam int V_ACTIVE = 304;
  localparam int V_COMMIT = 311;

  logic        clk7 = 1'b0;
  logic        rst_n;
  logic [8:0]  hc, vc;
  logic        pause;
  logic [3:0]  step;
  logic [7:0]  sin_addr;
  logic [15:0] sin_data = '0;
  logic [8:0]  angle;
  logic [16:0] u_stride, v_stride, u_start0, v_start0;
  logic        params_upd, busy, overrun;

  logic [15:0] rom [256];
  int          passed = 0;
  int          total  = 0;
  logic [8:0]  p_ang;
  logic [16:0] p_us, p_vs, p_u0, p_v0;
  logic [7:0]  la0, la1, la2;
  logic [8:0]  ang;

  typedef struct {
    logic        pz;
    logic [3:0]  st;
    logic [15:0] rv;
    logic [15:0] cv;
    logic [8:0]  ang;
    logic [16:0] us, vs, u0, v0;
  } vec_t;
  vec_t vecs [6];

  always #5 clk7 = ~clk7;
  always @(posedge clk7) sin_data <= rom[sin_addr];

  rotozoom_sched dut (
    .clk7(clk7), .rst_n(rst_n), .hc(hc), .vc(vc), .pause(pause), .step(step),
    .sin_addr(sin_addr), .sin_data(sin_data), .angle(angle),
    .u_stride(u_stride), .v_stride(v_stride), .u_start0(u_start0), .v_start0(v_start0),
    .params_upd(params_upd), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk7);
    #1;
  endtask

  task automatic fill(input logic [15:0] rv, input logic [15:0] cv, input logic [8:0] a);
    for (int i = 0; i < 256; i++) rom[i] = rv;
    rom[8'(a[7:0] + 8'd64)] = cv;
  endtask

  function automatic vec_t mk(input logic pz, input logic [3:0] st, input logic [8:0] a);
    mk = '{pz, st, 16'h4000, 16'h4000, a, 17'h00200, 17'h00200, 17'h1FFFF, 17'h00001};
  endfunction

  task automatic clear_prev();
    p_ang = '0; p_us = '0; p_vs = '0; p_u0 = '0; p_v0 = '0;
  endtask

  task automatic set_prev(input vec_t v);
    p_ang = v.ang; p_us = v.us; p_vs = v.vs; p_u0 = v.u0; p_v0 = v.v0;
  endtask

  // One full frame: trigger, 12 cycles of sequence/wait, commit, one idle cycle.
  task automatic run_frame(input vec_t v, input logic exp_ovr);
    int   nbusy = 0;
    int   nupd  = 0;
    logic hold_ok = 1'b1;
    fill(v.rv, v.cv, v.ang);
    pause = v.pz;
    step  = v.st;
    hc = 9'd0; vc = 9'(V_ACTIVE);
    chk("idle_busy", 32'(busy), 32'd0);
    tick();
    vc = 9'(V_ACTIVE + 1);
    for (int k = 1; k <= 12; k++) begin
      hc = 9'(k);
      if (k == 1) la0 = sin_addr;
      if (k == 2) la1 = sin_addr;
      if (k == 3) la2 = sin_addr;
      if (busy) nbusy++;
      if (params_upd) nupd++;
      if ({angle, u_stride, v_stride, u_start0, v_start0} !== {p_ang, p_us, p_vs, p_u0, p_v0})
        hold_ok = 1'b0;
      tick();
    end
    hc = 9'd0; vc = 9'(V_COMMIT);
    if (busy) nbusy++;
    if (params_upd) nupd++;
    if ({angle, u_stride, v_stride, u_start0, v_start0} !== {p_ang, p_us, p_vs, p_u0, p_v0})
      hold_ok = 1'b0;
    tick();
    if (busy) nbusy++;
    if (params_upd) nupd++;
    chk("angle",    32'(angle),    32'(v.ang));
    chk("u_stride", 32'(u_stride), 32'(v.us));
    chk("v_stride", 32'(v_stride), 32'(v.vs));
    chk("u_start0", 32'(u_start0), 32'(v.u0));
    chk("v_start0", 32'(v_start0), 32'(v.v0));
    hc = 9'd5; vc = 9'd0;
    tick();
    chk("busy_end", 32'(busy), 32'd0);
    chk("upd_end",  32'(params_upd), 32'd0);
    chk("busy_span", 32'(nbusy), 32'd14);
    chk("upd_count", 32'(nupd),  32'd1);
    chk("hold_before_commit", 32'(hold_ok), 32'd1);
    chk("addr_sin",   32'(la0), 32'(v.ang[7:0]));
    chk("addr_cos",   32'(la1), 32'(8'(v.ang[7:0] + 8'd64)));
    chk("addr_scale", 32'(la2), 32'(v.ang[8:1]));
    chk("overrun",    32'(overrun), 32'(exp_ovr));
    set_prev(v);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'd1, 16'h4000, 16'h4000, 9'd1, 17'h00200, 17'h00200, 17'h1FFFF, 17'h00001};
    vecs[1] = '{1'b0, 4'd1, 16'h4000, 16'hC000, 9'd2, 17'h1FE00, 17'h00200, 17'h00002, 17'h00001};
    vecs[2] = '{1'b1, 4'd5, 16'h7FFF, 16'h7FFF, 9'd2, 17'h007FF, 17'h007FF, 17'h1FFFD, 17'h00002};
    vecs[3] = '{1'b1, 4'd5, 16'hC000, 16'h4000, 9'd2, 17'h1FE00, 17'h00200, 17'h1FFFF, 17'h1FFFE};
    vecs[4] = '{1'b1, 4'd5, 16'h4000, 16'h4000, 9'd2, 17'h00200, 17'h00200, 17'h1FFFF, 17'h00001};
    vecs[5] = '{1'b0, 4'd5, 16'h4000, 16'h4000, 9'd7, 17'h00200, 17'h00200, 17'h1FFFF, 17'h00001};

    rst_n = 1'b0; hc = 9'd5; vc = 9'd0; pause = 1'b0; step = 4'd0;
    fill(16'h4000, 16'h4000, 9'd0);
    clear_prev();
    tick(); tick();
    chk("rst_angle",    32'(angle),      32'd0);
    chk("rst_u_stride", 32'(u_stride),   32'd0);
    chk("rst_v_stride", 32'(v_stride),   32'd0);
    chk("rst_u_start0", 32'(u_start0),   32'd0);
    chk("rst_v_start0", 32'(v_start0),   32'd0);
    chk("rst_upd",      32'(params_upd), 32'd0);
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_overrun",  32'(overrun),    32'd0);
    chk("rst_sin_addr", 32'(sin_addr),   32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_frame(vecs[i], 1'b0);

    ang = 9'd7;
    for (int i = 0; i < 12; i++) begin
      ang = ang + 9'd15;
      run_frame(mk(1'b0, 4'd15, ang), 1'b0);
    end
    run_frame(mk(1'b0, 4'd13, 9'd200), 1'b0);
    chk("addr200_f0", 32'(la0), 32'd200);
    chk("addr200_f1", 32'(la1), 32'd8);
    chk("addr200_f2", 32'(la2), 32'd100);

    ang = 9'd200;
    for (int i = 0; i < 20; i++) begin
      ang = ang + 9'd15;
      run_frame(mk(1'b0, 4'd15, ang), 1'b0);
    end
    run_frame(mk(1'b0, 4'd10, 9'd510), 1'b0);
    run_frame(mk(1'b0, 4'd5, 9'd3), 1'b0);
    chk("wrap_angle", 32'(angle), 32'd3);

    // Second trigger mid-sequence is ignored but flagged.
    fill(16'h4000, 16'h4000, 9'd8);
    pause = 1'b0; step = 4'd5;
    hc = 9'd0; vc = 9'(V_ACTIVE); tick();
    hc = 9'd1; vc = 9'(V_ACTIVE + 1); tick(); tick();
    hc = 9'd0; vc = 9'(V_ACTIVE); tick();
    chk("retrig_overrun", 32'(overrun), 32'd1);
    hc = 9'd1; vc = 9'(V_ACTIVE + 1); repeat (8) tick();
    hc = 9'd0; vc = 9'(V_COMMIT); tick();
    chk("retrig_upd",   32'(params_upd), 32'd1);
    chk("retrig_angle", 32'(angle),      32'd8);
    hc = 9'd5; vc = 9'd0; tick();
    set_prev(mk(1'b0, 4'd5, 9'd8));
    run_frame(mk(1'b0, 4'd1, 9'd9), 1'b1);

    rst_n = 1'b0; tick();
    chk("rst2_overrun", 32'(overrun), 32'd0);
    chk("rst2_angle",   32'(angle),   32'd0);
    rst_n = 1'b1; tick();
    clear_prev();
    run_frame(mk(1'b0, 4'd2, 9'd2), 1'b0);

    // Commit line arriving during M1 must not publish anything.
    pause = 1'b0; step = 4'd2;
    hc = 9'd0; vc = 9'(V_ACTIVE); tick();
    hc = 9'd1; vc = 9'(V_ACTIVE + 1); repeat (5) tick();
    hc = 9'd0; vc = 9'(V_COMMIT); tick();
    chk("early_upd",      32'(params_upd), 32'd0);
    chk("early_angle",    32'(angle),      32'd2);
    chk("early_u_start0", 32'(u_start0),   32'h1FFFF);
    chk("early_overrun",  32'(overrun),    32'd1);
    hc = 9'd1; vc = 9'(V_ACTIVE + 1); repeat (5) tick();
    hc = 9'd0; vc = 9'(V_COMMIT); tick();
    chk("late_upd",   32'(params_upd), 32'd1);
    chk("late_angle", 32'(angle),      32'd4);
    hc = 9'd5; vc = 9'd0; tick();

    // Reset asserted in M2 clears everything immediately.
    step = 4'd3;
    hc = 9'd0; vc = 9'(V_ACTIVE); tick();
    hc = 9'd1; vc = 9'(V_ACTIVE + 1); repeat (6) tick();
    chk("m2_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("m2rst_angle",    32'(angle),    32'd0);
    chk("m2rst_u_stride", 32'(u_stride), 32'd0);
    chk("m2rst_u_start0", 32'(u_start0), 32'd0);
    chk("m2rst_busy",     32'(busy),     32'd0);
    chk("m2rst_overrun",  32'(overrun),  32'd0);
    hc = 9'd5; vc = 9'd0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_prev();
    run_frame(mk(1'b0, 4'd3, 9'd3), 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
